// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge port between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, drives the imem req/ack port and
// loads the IF/ID register, with a one-entry skid buffer for decode stalls.
module fetch_stage #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [31:0]       NOP_INSTR = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              holdPC,
    input  logic              holdIF_ID,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    fetch_stage_if.master     imem,
    output logic [31:0]       IF_ID_instruction,
    output logic [ADDR_W-1:0] IF_ID_pc_plus4,
    output logic              IF_ID_valid
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] BUSY  = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    logic [1:0]        state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              req_nxt;
    logic [ADDR_W-1:0] addr_nxt, addr_plus4;
    // Skid occupancy is implied by state == FULL; no separate valid bit.
    logic [31:0]       skid_instr, skid_instr_nxt;
    logic [ADDR_W-1:0] skid_pc4, skid_pc4_nxt;
    logic [31:0]       ifid_instr_nxt;
    logic [ADDR_W-1:0] ifid_pc4_nxt;
    logic              ifid_valid_nxt;

    assign addr_plus4 = imem.imem_addr + ADDR_W'(4);

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        req_nxt        = imem.imem_req;
        addr_nxt       = imem.imem_addr;
        skid_instr_nxt = skid_instr;
        skid_pc4_nxt   = skid_pc4;
        ifid_instr_nxt = IF_ID_instruction;
        ifid_pc4_nxt   = IF_ID_pc_plus4;
        ifid_valid_nxt = IF_ID_valid;

        // Decode not stalled: default to a bubble unless something loads below.
        if (!holdIF_ID) begin
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
        end

        case (state)
            IDLE: begin
                if (!branch_taken && !holdPC) begin
                    req_nxt   = 1'b1;
                    addr_nxt  = pc;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (imem.imem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                    if (!branch_taken) begin
                        pc_nxt = addr_plus4;
                        if (holdIF_ID) begin
                            skid_instr_nxt = imem.imem_rdata;
                            skid_pc4_nxt   = addr_plus4;
                            state_nxt      = FULL;
                        end else begin
                            ifid_instr_nxt = imem.imem_rdata;
                            ifid_pc4_nxt   = addr_plus4;
                            ifid_valid_nxt = 1'b1;
                            if (!holdPC) begin
                                req_nxt   = 1'b1;
                                addr_nxt  = addr_plus4;
                                state_nxt = BUSY;
                            end
                        end
                    end
                end else if (branch_taken) begin
                    // Request must stay up until the memory answers; answer is dropped.
                    state_nxt = DRAIN;
                end
            end
            FULL: begin
                if (branch_taken) begin
                    state_nxt = IDLE;
                end else if (!holdIF_ID) begin
                    ifid_instr_nxt = skid_instr;
                    ifid_pc4_nxt   = skid_pc4;
                    ifid_valid_nxt = 1'b1;
                    state_nxt      = IDLE;
                end
            end
            DRAIN: begin
                if (imem.imem_ack) begin
                    req_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Redirect wins over both holds and over anything loaded above.
        if (branch_taken) begin
            pc_nxt         = branch_target & ~{{(ADDR_W-2){1'b0}}, 2'b11};
            ifid_instr_nxt = NOP_INSTR;
            ifid_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            imem.imem_req     <= 1'b0;
            imem.imem_addr    <= RESET_PC;
            skid_instr        <= NOP_INSTR;
            skid_pc4          <= '0;
            IF_ID_instruction <= NOP_INSTR;
            IF_ID_pc_plus4    <= '0;
            IF_ID_valid       <= 1'b0;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            imem.imem_req     <= req_nxt;
            imem.imem_addr    <= addr_nxt;
            skid_instr        <= skid_instr_nxt;
            skid_pc4          <= skid_pc4_nxt;
            IF_ID_instruction <= ifid_instr_nxt;
            IF_ID_pc_plus4    <= ifid_pc4_nxt;
            IF_ID_valid       <= ifid_valid_nxt;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns instr = addr; every IF_ID load
// is checked against a queue of expected {instr, pc_plus4}.
module tb_fetch_stage;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        holdPC = 1'b0;
    logic        holdIF_ID = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_pc_plus4;
    logic        IF_ID_valid;

    fetch_stage_if #(.ADDR_W(32)) mem_bus ();

    fetch_stage #(.ADDR_W(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .holdPC            (holdPC),
        .holdIF_ID         (holdIF_ID),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .imem              (mem_bus),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_pc_plus4    (IF_ID_pc_plus4),
        .IF_ID_valid       (IF_ID_valid)
    );

    always #5 clk = ~clk;

    // Memory model with programmable wait states; drops its count on reset.
    int waits = 0;
    int wcnt;
    assign mem_bus.imem_ack   = mem_bus.imem_req && (wcnt == waits);
    assign mem_bus.imem_rdata = mem_bus.imem_addr;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                wcnt <= 0;
        else if (mem_bus.imem_ack) wcnt <= 0;
        else if (mem_bus.imem_req) wcnt <= wcnt + 1;
    end

    int          n_cmp = 0;
    int          n_err = 0;
    logic        hold_at_edge;
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input logic [31:0] a);
        exp_q.push_back({a, a + 32'd4});
    endtask

    // One clock; at the falling edge, score any IF_ID load made at the rising edge.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        hold_at_edge = holdIF_ID;
        @(negedge clk);
        if (IF_ID_valid && !hold_at_edge) begin
            chk("sb_have_expect", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_instr", {32'h0, IF_ID_instruction}, {32'h0, e[63:32]});
                chk("sb_pc4", {32'h0, IF_ID_pc_plus4}, {32'h0, e[31:0]});
            end
        end else if (!IF_ID_valid && !hold_at_edge) begin
            chk("bubble_nop", {32'h0, IF_ID_instruction}, {32'h0, NOP});
        end
    endtask

    initial begin
        // Reset state
        tick(); tick();
        chk("rst_req", 64'(mem_bus.imem_req), 64'd0);
        chk("rst_addr", 64'(mem_bus.imem_addr), 64'd0);
        chk("rst_valid", 64'(IF_ID_valid), 64'd0);
        chk("rst_instr", 64'(IF_ID_instruction), 64'(NOP));
        chk("rst_pc4", 64'(IF_ID_pc_plus4), 64'd0);
        rst_n = 1'b1;

        // 1: zero-wait streaming
        for (int i = 0; i < 7; i++) expect_instr(32'(i * 4));
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk("p1_addr", 64'(mem_bus.imem_addr), 64'((k - 1) * 4));
            chk("p1_req", 64'(mem_bus.imem_req), 64'd1);
            chk("p1_valid", 64'(IF_ID_valid), 64'(k >= 2));
        end
        chk("p1_instr", 64'(IF_ID_instruction), 64'h0C);

        // 2: stall on the cycle 0x10 returns
        holdPC = 1'b1; holdIF_ID = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("p2_hold_instr", 64'(IF_ID_instruction), 64'h0C);
            chk("p2_hold_valid", 64'(IF_ID_valid), 64'd1);
            chk("p2_hold_req", 64'(mem_bus.imem_req), 64'd0);
        end
        holdPC = 1'b0; holdIF_ID = 1'b0;
        tick();
        chk("p2_unpark", 64'(IF_ID_instruction), 64'h10);
        tick();
        chk("p2_next_addr", 64'(mem_bus.imem_addr), 64'h14);
        chk("p2_next_req", 64'(mem_bus.imem_req), 64'd1);
        tick();
        holdPC = 1'b1;
        tick(); tick();
        chk("p2_drained", 64'(exp_q.size()), 64'd0);
        chk("p2_idle_req", 64'(mem_bus.imem_req), 64'd0);

        // 3: three wait states
        waits = 3;
        expect_instr(32'h1C); expect_instr(32'h20);
        holdPC = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("p3_req", 64'(mem_bus.imem_req), 64'd1);
            chk("p3_addr", 64'(mem_bus.imem_addr), 64'h1C);
            chk("p3_wait_valid", 64'(IF_ID_valid), 64'd0);
        end
        tick();
        chk("p3_load_valid", 64'(IF_ID_valid), 64'd1);
        chk("p3_next_addr", 64'(mem_bus.imem_addr), 64'h20);
        tick();
        chk("p3_pulse_valid", 64'(IF_ID_valid), 64'd0);
        holdPC = 1'b1;
        repeat (4) tick();
        chk("p3_drained", 64'(exp_q.size()), 64'd0);

        // 4: branch while BUSY, ack two cycles away
        waits = 2;
        expect_instr(32'h100);
        holdPC = 1'b0;
        tick();
        chk("p4_addr", 64'(mem_bus.imem_addr), 64'h24);
        branch_taken = 1'b1; branch_target = 32'h103;
        tick();
        branch_taken = 1'b0;
        chk("p4_flush_valid", 64'(IF_ID_valid), 64'd0);
        chk("p4_flush_instr", 64'(IF_ID_instruction), 64'(NOP));
        chk("p4_drain_req", 64'(mem_bus.imem_req), 64'd1);
        chk("p4_drain_addr", 64'(mem_bus.imem_addr), 64'h24);
        tick();
        chk("p4_drain_addr2", 64'(mem_bus.imem_addr), 64'h24);
        tick();
        chk("p4_idle_req", 64'(mem_bus.imem_req), 64'd0);
        tick();
        chk("p4_target_addr", 64'(mem_bus.imem_addr), 64'h100);
        chk("p4_target_req", 64'(mem_bus.imem_req), 64'd1);
        holdPC = 1'b1;
        repeat (3) tick();
        chk("p4_instr", 64'(IF_ID_instruction), 64'h100);
        chk("p4_pc4", 64'(IF_ID_pc_plus4), 64'h104);
        tick();
        chk("p4_drained", 64'(exp_q.size()), 64'd0);

        // 5: branch coincident with ack under holdIF_ID
        waits = 0;
        expect_instr(32'h104); expect_instr(32'h200);
        holdPC = 1'b0;
        tick(); tick();
        chk("p5_pre_valid", 64'(IF_ID_valid), 64'd1);
        branch_taken = 1'b1; branch_target = 32'h200; holdIF_ID = 1'b1;
        tick();
        branch_taken = 1'b0; holdIF_ID = 1'b0;
        chk("p5_flush_valid", 64'(IF_ID_valid), 64'd0);
        chk("p5_flush_instr", 64'(IF_ID_instruction), 64'(NOP));
        chk("p5_req", 64'(mem_bus.imem_req), 64'd0);
        tick();
        chk("p5_target_addr", 64'(mem_bus.imem_addr), 64'h200);
        holdPC = 1'b1;
        tick(); tick();
        chk("p5_drained", 64'(exp_q.size()), 64'd0);

        // PC wrap: redirect from IDLE to the top word
        branch_taken = 1'b1; branch_target = 32'hFFFF_FFFE;
        tick();
        branch_taken = 1'b0; holdPC = 1'b0;
        expect_instr(32'hFFFF_FFFC); expect_instr(32'h0);
        tick();
        chk("wrap_addr", 64'(mem_bus.imem_addr), 64'hFFFF_FFFC);
        tick();
        chk("wrap_next_addr", 64'(mem_bus.imem_addr), 64'h0);
        holdPC = 1'b1;
        tick(); tick();
        chk("wrap_drained", 64'(exp_q.size()), 64'd0);

        // 6: asynchronous reset mid-BUSY
        holdPC = 1'b0;
        expect_instr(32'h4);
        tick(); tick();
        chk("p6_pre_valid", 64'(IF_ID_valid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("p6_rst_req", 64'(mem_bus.imem_req), 64'd0);
        chk("p6_rst_valid", 64'(IF_ID_valid), 64'd0);
        chk("p6_rst_addr", 64'(mem_bus.imem_addr), 64'd0);
        tick();
        rst_n = 1'b1;
        expect_instr(32'h0); expect_instr(32'h4);
        tick();
        chk("p6_restart_addr", 64'(mem_bus.imem_addr), 64'd0);
        tick();
        holdPC = 1'b1;
        tick(); tick();
        chk("p6_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS core.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Loads the IF/ID register consumed by decode and by the hazard detector, which reads `IF_ID_instruction`.
- Obeys the `holdPC`/`holdIF_ID` stall requests from the hazard detector and the branch redirect from execute.

Parameters:
- ADDR_W, 32, PC and memory address width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INSTR, 32'h0000_0000, instruction word inserted for bubbles and flushes.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- holdPC  input  1  freeze PC; no new fetch may be issued.
- holdIF_ID  input  1  freeze IF/ID register contents.
- branch_taken  input  1  one-cycle redirect pulse.
- branch_target  input  ADDR_W  redirect address.
- imem_req  output  1  registered; fetch request.
- imem_addr  output  ADDR_W  registered; word-aligned fetch address.
- imem_ack  input  1  response strobe, valid only while imem_req=1.
- imem_rdata  input  32  instruction word, valid with imem_ack.
- IF_ID_instruction  output  32  decoded-stage instruction.
- IF_ID_pc_plus4  output  ADDR_W  address of that instruction + 4.
- IF_ID_valid  output  1  1 = real instruction, 0 = bubble.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC; imem_req=0; imem_addr=RESET_PC.
  - IF_ID_instruction=NOP_INSTR; IF_ID_pc_plus4=0; IF_ID_valid=0.
  - Skid buffer empty; state=IDLE.
- States: IDLE, BUSY, FULL, DRAIN.
- Memory protocol: while imem_req=1 and imem_ack=0, imem_addr is held stable and imem_req stays high. A transaction completes on the cycle imem_ack=1.
- IDLE:
  - If !holdPC and !branch_taken: next imem_req=1, imem_addr=pc, go BUSY.
  - Otherwise stay IDLE with imem_req=0.
- BUSY, ack=1, no branch:
  - Capture rdata; pc<=imem_addr+4.
  - If holdIF_ID=0: IF_ID_instruction<=rdata, IF_ID_pc_plus4<=imem_addr+4, IF_ID_valid<=1.
  - If holdIF_ID=1: rdata and imem_addr+4 go to the skid buffer and the state goes FULL, with imem_req<=0.
  - If holdIF_ID=0 and holdPC=0: back-to-back fetch. imem_req stays 1, imem_addr<=imem_addr+4, stay BUSY. This gives throughput of 1 instruction/cycle with a zero-wait memory.
  - If holdIF_ID=0 and holdPC=1: imem_req<=0, go IDLE.
- FULL:
  - No request is issued.
  - When holdIF_ID=0: IF_ID loads from the skid buffer (valid=1), buffer clears, go IDLE.
- Bubble rule: on any edge where holdIF_ID=0 and no instruction is loaded, IF_ID_valid<=0 and IF_ID_instruction<=NOP_INSTR.
- Hold rule: holdIF_ID=1 keeps all three IF_ID outputs unchanged, except on branch.
- branch_taken, highest priority, overrides both holds:
  - pc<=branch_target with bits[1:0] forced to 0.
  - IF_ID flushed to NOP_INSTR with valid=0; skid buffer cleared.
  - If in BUSY with ack=0: go DRAIN. imem_req stays 1 at the old address until ack; the response is discarded; then imem_req<=0 and go IDLE.
  - If in BUSY with ack=1 on the same cycle: discard rdata, imem_req<=0, go IDLE.
  - If in IDLE or FULL: go IDLE.
  - A second branch_taken while in DRAIN updates pc only.
- Latency from IDLE to IF_ID_valid=1 is 2 cycles with zero-wait memory: request edge, then the load edge on ack.
- PC arithmetic is modulo 2^ADDR_W: pc 32'hFFFF_FFFC advances to 0.
- Reset mid-transaction: all state returns to reset values at once. The outstanding request is abandoned, and the memory model must drop it.

Test Plan:
1. Reset, zero-wait memory returning instr = addr, no holds: imem_addr 0,4,8,… on consecutive cycles. IF_ID_instruction 0,4,8 with IF_ID_pc_plus4 4,8,C and valid=1 from the 2nd cycle after reset release.
2. Steady fetch, then holdPC=holdIF_ID=1 for 3 cycles on the cycle ack returns addr 0x10:
   - IF_ID unchanged during the hold; instr 0x10 parked in the skid buffer.
   - After release, IF_ID=0x10 on the next edge.
   - Next request issued to 0x14; no instruction lost or duplicated.
3. Memory with 3 wait states: imem_req/imem_addr stable for 4 cycles per fetch. IF_ID_valid pulses 1 cycle per fetch, and bubbles carry instruction=NOP_INSTR.
4. branch_taken with target 0x103 while BUSY, ack delayed 2 cycles:
   - IF_ID flushed (valid=0).
   - Stale response discarded.
   - Next imem_addr=0x100; IF_ID next shows instr 0x100 with pc_plus4=0x104.
5. branch_taken on the same cycle as ack and holdIF_ID=1: IF_ID flushes despite the hold, rdata is dropped, and the next fetch is from the target.
6. rst_n asserted mid-BUSY (asynchronous, between clock edges): imem_req=0, IF_ID_valid=0, imem_addr=RESET_PC immediately. After release, fetch restarts at RESET_PC.
